// File: rtl/sm_hex_display_scan.sv
// sm_hex_display_scan
//   Latches a 32-bit value from the CPU's display register and scans it onto
//   a time-multiplexed hex 7-segment display, one digit at a time. New values
//   are staged in a shadow register and only reach the display at a frame
//   boundary, so a frame never mixes old and new digits. With the scan
//   disabled, a load goes straight to the display.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   value_in   : value to display (only the low 4*DIGITS bits are used)
//   load       : capture value_in this cycle
//   en         : scan enable; 0 blanks the display and parks the scan
//   blank_lz   : enable leading-zero blanking (digit 0 always shown)
//   seg        : segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an         : digit selects, an[i] = nibble i, polarity per AN_ACTIVE_LOW
//   frame_done : one-cycle pulse when the scan wraps from the last digit
module sm_hex_display_scan #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 1024,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       value_in,
    input  logic              load,
    input  logic              en,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [VW-1:0] shadow;
    logic [VW-1:0] disp;
    logic          pending;
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    logic              presc_wrap;
    logic              frame_wrap;
    logic [3:0]        digit_nibble;
    logic [DIGITS-1:0] lz_blank;
    logic              nz_seen;
    logic              digit_on;
    logic [DIGITS-1:0] an_lit;
    logic [6:0]        seg_lit;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        presc_wrap   = en && (presc == PRESC_LAST);
        frame_wrap   = presc_wrap && (idx == IDX_LAST);
        digit_nibble = disp[4*idx +: 4];

        // Walk from the most significant digit down; a digit is a leading
        // zero while no nonzero nibble has been seen at or above it.
        nz_seen  = 1'b0;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen     = nz_seen | (disp[4*i +: 4] != 4'h0);
            lz_blank[i] = (i != 0) && !nz_seen;
        end

        // A blanked digit still occupies its slot; it just stays dark.
        digit_on = en && !(blank_lz && lz_blank[idx]);
        an_lit   = digit_on ? (DIGITS'(1) << idx) : '0;
        seg_lit  = digit_on ? hex_decode(digit_nibble) : 7'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end else begin
            if (en) begin
                presc <= presc_wrap ? '0 : presc + 1'b1;
                if (presc_wrap)
                    idx <= frame_wrap ? '0 : idx + 1'b1;
            end else begin
                presc <= '0;
                idx   <= '0;
            end
            frame_done <= frame_wrap;

            // A load on the boundary cycle wins over the staged value, and
            // with the scan parked there is no frame to protect.
            if (load) begin
                shadow <= value_in[VW-1:0];
                if (!en || frame_wrap) begin
                    disp    <= value_in[VW-1:0];
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (frame_wrap && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end

            an  <= AN_ACTIVE_LOW ? ~an_lit : an_lit;
            seg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        end
    end

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// tb_sm_hex_display_scan
//   Directed bench for sm_hex_display_scan with DIGITS=4, SCAN_DIV=4 and
//   active-low digit and segment drive. Expected segment codes are the
//   hand-inverted hex patterns (e.g. "4" = ~7'h66 = 7'h19).
module tb_sm_hex_display_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] value_in;
    logic        load;
    logic        en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    sm_hex_display_scan #(
        .DIGITS(4),
        .SCAN_DIV(4),
        .AN_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_in(value_in),
        .load(load),
        .en(en),
        .blank_lz(blank_lz),
        .seg(seg),
        .an(an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, settle, and drop any one-shot load.
    task automatic tick();
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] an_exp,
                             input logic [6:0] seg_exp, input logic fd_exp);
        total++;
        assert (an === an_exp) else begin
            bad++;
            $error("FAIL %s an: got %b want %b", tag, an, an_exp);
        end
        total++;
        assert (seg === seg_exp) else begin
            bad++;
            $error("FAIL %s seg: got %h want %h", tag, seg, seg_exp);
        end
        total++;
        assert (frame_done === fd_exp) else begin
            bad++;
            $error("FAIL %s frame_done: got %b want %b", tag, frame_done, fd_exp);
        end
    endtask

    // One digit slot (4 clocks); frame_done expected on the last clock of
    // the last slot only.
    task automatic expect_digit(input int d, input logic [6:0] s,
                                input logic blanked, input logic last);
        logic [3:0] a_exp;
        a_exp = 4'hF;
        if (!blanked) a_exp[d] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out($sformatf("d%0d_c%0d", d, c), a_exp,
                      blanked ? 7'h7F : s, last && (c == 3));
        end
    endtask

    task automatic expect_frame(input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [3:0] bl);
        expect_digit(0, s0, bl[0], 1'b0);
        expect_digit(1, s1, bl[1], 1'b0);
        expect_digit(2, s2, bl[2], 1'b0);
        expect_digit(3, s3, bl[3], 1'b1);
    endtask

    // Run until the frame_done pulse, bounded.
    task automatic wait_frame(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            seen = frame_done;
        end
        total++;
        assert (seen === 1'b1) else begin
            bad++;
            $error("FAIL %s frame_done: got none in 40 cycles want pulse", tag);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        value_in = 32'h0;
        load     = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;

        // Reset held three cycles, then first post-reset cycle shows "0".
        tick(); tick(); tick();
        check_out("reset", 4'hF, 7'h7F, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("post_reset", 4'hE, 7'h40, 1'b0);

        // Basic load, applied at the next frame boundary.
        value_in = 32'h1234;
        load     = 1'b1;
        tick();
        wait_frame("load_1234");
        expect_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);

        // No tearing: load mid-frame, old digits finish the frame.
        expect_digit(0, 7'h19, 1'b0, 1'b0);
        value_in = 32'hABCD;
        load     = 1'b1;
        expect_digit(1, 7'h30, 1'b0, 1'b0);
        expect_digit(2, 7'h24, 1'b0, 1'b0);
        expect_digit(3, 7'h79, 1'b0, 1'b1);
        expect_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b0000);

        // Boundary collision: 0x5555 pending, 0xFFFF loaded on boundary.
        value_in = 32'h5555;
        load     = 1'b1;
        expect_digit(0, 7'h21, 1'b0, 1'b0);
        expect_digit(1, 7'h46, 1'b0, 1'b0);
        expect_digit(2, 7'h03, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out($sformatf("pre_bound_c%0d", c), 4'h7, 7'h08, 1'b0);
        end
        value_in = 32'hFFFF;
        load     = 1'b1;
        tick();
        check_out("bound", 4'h7, 7'h08, 1'b1);
        expect_frame(7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0000);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        value_in = 32'h0005;
        load     = 1'b1;
        expect_frame(7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'b0000);
        value_in = 32'h0000;
        load     = 1'b1;
        expect_frame(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b1110);
        expect_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1110);
        blank_lz = 1'b0;
        expect_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

        // Scan disabled: dark display, load applied immediately.
        en = 1'b0;
        tick();
        check_out("en0_a", 4'hF, 7'h7F, 1'b0);
        value_in = 32'h00C0;
        load     = 1'b1;
        tick();
        check_out("en0_load", 4'hF, 7'h7F, 1'b0);
        tick();
        check_out("en0_b", 4'hF, 7'h7F, 1'b0);
        en       = 1'b1;
        blank_lz = 1'b1;
        expect_frame(7'h40, 7'h46, 7'h7F, 7'h7F, 4'b1100);

        // Reset mid-frame discards a pending load.
        blank_lz = 1'b0;
        value_in = 32'h7777;
        load     = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        check_out("mid_reset", 4'hF, 7'h7F, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("mid_reset_rel", 4'hE, 7'h40, 1'b0);
        wait_frame("after_reset");
        expect_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
